// File: rtl/dot_cursor_mover_if.sv
// Bus between the cursor mover and its surroundings: keypad codes in, cursor
// position, move pulse and 8x8 dot-matrix drive out.
interface dot_cursor_mover_if;
    logic [1:0] vir;
    logic [1:0] hor;
    logic [2:0] x;
    logic [2:0] y;
    logic       moved;
    logic [7:0] dm_row;
    logic [7:0] dm_col;

    modport master (
        output vir, hor,
        input  x, y, moved, dm_row, dm_col
    );

    modport slave (
        input  vir, hor,
        output x, y, moved, dm_row, dm_col
    );
endinterface

// File: rtl/dot_cursor_mover.sv
// Keypad-driven cursor on an 8x8 grid with auto-repeat while a direction is
// held, plus a row-scanned dot-matrix driver showing the cursor position.
module dot_cursor_mover #(
    parameter int STEP_DIV = 16,
    parameter int SCAN_DIV = 4,
    parameter int WRAP     = 0,
    parameter int X0       = 3,
    parameter int Y0       = 3
) (
    input  logic               clk,
    input  logic               reset,
    dot_cursor_mover_if.slave  bus
);
    localparam int CW = $clog2(STEP_DIV);
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_STEP = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    logic [3:0]    dir_reg;
    logic [3:0]    step_dir_reg, step_dir_next;
    logic [1:0]    state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [2:0]    x_reg, x_next;
    logic [2:0]    y_reg, y_next;
    logic          moved_reg, moved_next;
    logic [SW-1:0] scan_reg, scan_next;
    logic [2:0]    r_reg, r_next;
    logic [7:0]    dm_row_reg, dm_row_next;
    logic [7:0]    dm_col_reg, dm_col_next;
    logic [7:0]    row_onehot, col_onehot;
    logic          dir_active;

    // Codes 00 and 11 are both "no move"; only 10/01 decode to a direction.
    assign dir_active = (^dir_reg[3:2]) | (^dir_reg[1:0]);

    function automatic logic [2:0] step_axis(input logic [2:0] pos, input logic [1:0] code);
        case (code)
            2'b10:   return (pos == 3'd0 && WRAP == 0) ? pos : pos - 3'd1;
            2'b01:   return (pos == 3'd7 && WRAP == 0) ? pos : pos + 3'd1;
            default: return pos;
        endcase
    endfunction

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        step_dir_next = step_dir_reg;
        x_next        = x_reg;
        y_next        = y_reg;
        case (state_reg)
            S_IDLE: begin
                if (dir_active) begin
                    state_next    = S_STEP;
                    step_dir_next = dir_reg;
                end
            end
            S_STEP: begin
                x_next     = step_axis(x_reg, step_dir_reg[3:2]);
                y_next     = step_axis(y_reg, step_dir_reg[1:0]);
                cnt_next   = CW'(STEP_DIV - 1);
                state_next = S_HOLD;
            end
            S_HOLD: begin
                // The direction is captured when entering S_STEP, so a key
                // change mid-hold neither restarts the count nor is lost.
                if (!dir_active) begin
                    state_next = S_IDLE;
                end else if (cnt_reg == CW'(1)) begin
                    cnt_next      = '0;
                    state_next    = S_STEP;
                    step_dir_next = dir_reg;
                end else begin
                    cnt_next = cnt_reg - CW'(1);
                end
            end
            default: state_next = S_IDLE;
        endcase
        moved_next = (x_next != x_reg) || (y_next != y_reg);
    end

    always_comb begin
        scan_next = scan_reg + SW'(1);
        r_next    = r_reg;
        if (scan_reg == SW'(SCAN_DIV - 1)) begin
            scan_next = '0;
            r_next    = r_reg + 3'd1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_dec
            assign row_onehot[gi] = (r_next == 3'(gi));
            assign col_onehot[gi] = (x_next == 3'(gi));
        end
    endgenerate

    // Built from next-state values so the row strobe and its column data
    // always change together and track the cursor without a lag.
    assign dm_row_next = ~row_onehot;
    assign dm_col_next = (r_next == y_next) ? col_onehot : 8'h00;

    always_ff @(posedge clk) begin
        if (reset) begin
            dir_reg      <= 4'b0000;
            step_dir_reg <= 4'b0000;
            state_reg    <= S_IDLE;
            cnt_reg      <= '0;
            x_reg        <= 3'(X0);
            y_reg        <= 3'(Y0);
            moved_reg    <= 1'b0;
            scan_reg     <= '0;
            r_reg        <= 3'd0;
            dm_row_reg   <= 8'hFE;
            dm_col_reg   <= 8'h00;
        end else begin
            dir_reg      <= {bus.vir, bus.hor};
            step_dir_reg <= step_dir_next;
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            x_reg        <= x_next;
            y_reg        <= y_next;
            moved_reg    <= moved_next;
            scan_reg     <= scan_next;
            r_reg        <= r_next;
            dm_row_reg   <= dm_row_next;
            dm_col_reg   <= dm_col_next;
        end
    end

    assign bus.x      = x_reg;
    assign bus.y      = y_reg;
    assign bus.moved  = moved_reg;
    assign bus.dm_row = dm_row_reg;
    assign bus.dm_col = dm_col_reg;
endmodule
